imem_load_controller: RTL

//  Sequences the instruction RAM port: in LOAD mode, assembles UART bytes into words and writes them
//  to consecutive addresses; in RUN mode, drives the fetch address, advancing one word per step pulse.

---
 rtl/imem_load_controller.sv | 136 +++++++++++++
 1 files changed

// File: rtl/imem_load_controller.sv
// Loads UART bytes into the instruction RAM as little-endian words (LOAD), then steps the fetch address (RUN).
// Latency: a word is written 1 clk after its last byte; button edges act 2 clks after the input rises.
// Backpressure: none; bytes that arrive outside LOAD are dropped and flagged in the sticky rx_dropped.
module imem_load_controller #(
    parameter int N           = 2,
    parameter int MAX_ADDRESS = 3,
    parameter int WORD_BYTES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    input  logic                    load_req,
    input  logic                    step,
    output logic [N-1:0]            ram_addr,
    output logic [8*WORD_BYTES-1:0] ram_wdata,
    output logic                    ram_we,
    output logic                    loading,
    output logic                    running,
    output logic                    load_done,
    output logic [N:0]              words_loaded,
    output logic                    rx_dropped
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam logic [N-1:0] LAST_ADDR = N'(MAX_ADDRESS);
    localparam logic [2:0]   LAST_BYTE = 3'(WORD_BYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
    state_t state_q, state_d;

    logic              load_cur, load_prv, step_cur, step_prv;
    logic              load_edge, step_edge;
    logic [2:0]        byte_cnt;
    logic [DATA_W-1:0] asm_q, asm_next;
    logic              fin_pend;
    logic              take_byte, word_done, write_last, finish;

    assign load_edge = load_cur & ~load_prv;
    assign step_edge = step_cur & ~step_prv;
    assign loading   = (state_q == S_LOAD);
    assign running   = (state_q == S_RUN);

    always_comb begin
        take_byte  = (state_q == S_LOAD) && rx_valid && !fin_pend;
        word_done  = take_byte && (byte_cnt == LAST_BYTE);
        write_last = ram_we && (ram_addr == LAST_ADDR);
        asm_next   = asm_q;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (byte_cnt == 3'(i)) asm_next[8*i +: 8] = rx_data;
        end
        // A finish request that coincides with a completing word waits for that word's write.
        finish = (state_q == S_LOAD) &&
                 (write_last || fin_pend || (load_edge && !word_done));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (load_edge) state_d = S_LOAD;
            S_LOAD:  if (finish)    state_d = S_RUN;
            S_RUN:   if (load_edge) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cur     <= 1'b0;
            load_prv     <= 1'b0;
            step_cur     <= 1'b0;
            step_prv     <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_we       <= 1'b0;
            load_done    <= 1'b0;
            words_loaded <= '0;
            rx_dropped   <= 1'b0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            fin_pend     <= 1'b0;
        end else begin
            load_cur  <= load_req;
            load_prv  <= load_cur;
            step_cur  <= step;
            step_prv  <= step_cur;
            ram_we    <= 1'b0;
            load_done <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (ram_we) begin
                        ram_addr     <= ram_addr + N'(1);
                        words_loaded <= words_loaded + (N+1)'(1);
                    end
                    if (take_byte) begin
                        if (word_done) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= asm_next;
                            byte_cnt  <= '0;
                            asm_q     <= '0;
                        end else begin
                            asm_q    <= asm_next;
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                    if (load_edge && word_done) fin_pend <= 1'b1;
                    if (finish) begin
                        ram_addr  <= '0;
                        ram_we    <= 1'b0;
                        load_done <= 1'b1;
                        byte_cnt  <= '0;
                        asm_q     <= '0;
                        fin_pend  <= 1'b0;
                    end
                end
                default: begin
                    if (rx_valid) rx_dropped <= 1'b1;
                    if (load_edge) begin
                        ram_addr     <= '0;
                        words_loaded <= '0;
                        rx_dropped   <= 1'b0;
                        byte_cnt     <= '0;
                        asm_q        <= '0;
                        fin_pend     <= 1'b0;
                    end else if (step_edge && state_q == S_RUN) begin
                        ram_addr <= (ram_addr == LAST_ADDR) ? '0 : ram_addr + N'(1);
                    end
                end
            endcase
        end
    end
endmodule
